siftkey_bram_sched: RTL and testbench
=====================================

Name: siftkey_bram_sched

Overview:
- Schedules Alice's single-port sifted-key BRAM (64 b x 32768) as a circular buffer.
- Shared between two requesters: the sifting engine (writer) and the post-processing reader.
- Per cycle, it grants at most one access, tracks fill level, and enforces reader anti-starvation.
- Sequences the end-of-sifting drain and signals completion.

Parameters:
- ADDR_W, 15, BRAM address width; depth = 2^ADDR_W.
- DATA_W, 64, key word width.
- RD_LATENCY, 2, BRAM read latency in cycles (1..4).
- WR_BURST_MAX, 8, maximum consecutive writer grants while the reader is pending and the buffer is non-empty.

Ports:
- clk  in  1  single clock for the block and the BRAM port.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  synchronous pulse; empties the buffer and returns to RUN.
- wr_req  in  1  writer has a word.
- wr_data  in  DATA_W  word to write.
- wr_ack  out  1  write accepted this cycle (combinational).
- rd_req  in  1  reader wants a word.
- rd_ack  out  1  read issued this cycle (combinational).
- rd_data  out  DATA_W  read word, valid with rd_valid.
- rd_valid  out  1  rd_data valid; fires RD_LATENCY cycles after rd_ack.
- sift_finish  in  1  pulse; the writer has produced its last word.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data.
- bram_en  out  1  BRAM enable (wr_ack | rd_ack).
- bram_we  out  1  BRAM write enable (= wr_ack).
- level  out  ADDR_W+1  words stored.
- full  out  1  level == 2^ADDR_W.
- empty  out  1  level == 0.
- drain_done  out  1  level signal: DONE state.
- stall_wr_cnt  out  32  writer stall cycles (optional feature).
- stall_rd_cnt  out  32  reader stall cycles (optional feature).

Behaviour:
- Reset (and restart) values:
  - wr_ptr = rd_ptr = 0, level = 0.
  - full = 0, empty = 1.
  - rd_valid = 0 with the pipeline flushed; rd_data = 0.
  - burst_cnt = 0, state = RUN, drain_done = 0.
  - reset has priority over restart.
- States:
  - RUN: writes and reads allowed.
  - DRAIN: entered on sift_finish in RUN. wr_ack is forced to 0; reads continue.
  - DONE: entered from DRAIN when empty = 1 and no read is in flight. drain_done = 1, all acks = 0. Left only via reset or restart.
- Simultaneous sift_finish and wr_ack in RUN: the write is accepted, then the state goes to DRAIN.
- Eligibility:
  - Writer: wr_req & ~full & state == RUN.
  - Reader: rd_req & ~empty & state != DONE.
- Arbitration, when both are eligible:
  - Writer wins unless burst_cnt == WR_BURST_MAX, in which case the reader wins.
  - burst_cnt increments on each writer grant while the reader is eligible.
  - burst_cnt clears on a reader grant or whenever the reader is not eligible.
- At most one of wr_ack / rd_ack is high per cycle.
- On write: bram_addr = wr_ptr, bram_din = wr_data. Next cycle: wr_ptr + 1 (wraps modulo 2^ADDR_W), level + 1.
- On read: bram_addr = rd_ptr. Next cycle: rd_ptr + 1 (wraps), level - 1.
- When idle: bram_en = 0, bram_we = 0, bram_addr holds its last value.
- rd_valid is a RD_LATENCY-deep shift of rd_ack. rd_data is registered from bram_dout in the cycle the tap fires.
- Ordering and boundaries:
  - Data is read out strictly in FIFO order.
  - Writing while full is impossible (no ack); the writer must hold wr_req and wr_data until acked.
  - Reading while empty yields no ack.
- restart mid-read: in-flight reads are dropped and rd_valid does not fire for them.

Optional Feature:
- Macro SIFTKEY_SCHED_STATS_EN.
- Defined:
  - stall_wr_cnt increments each cycle wr_req = 1 and wr_ack = 0 in RUN.
  - stall_rd_cnt increments each cycle rd_req = 1 and rd_ack = 0 in non-DONE states.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset/restart.
- Not defined: both outputs are tied to 0 and no counter logic is generated.

Decomposition:
- Package siftkey_pkg holds:
  - SIFTKEY_ADDR_W = 15 and SIFTKEY_DATA_W = 64.
  - The state enum sched_state_t {RUN, DRAIN, DONE}.
  - The RD_LATENCY default.
- One sub-module, siftkey_grant_arb: two-requester priority arbiter with burst_cnt starvation guard, producing the wr/rd grants.
- Pointers, level, read pipeline and FSM stay in the top.

Test Plan:
- Write 5 words 0x11..0x15, then read 5 → rd_valid 2 cycles after each rd_ack; data 0x11..0x15 in order; level 5→0; empty = 1.
- Preload 4 words; hold wr_req and rd_req high for 20 cycles (WR_BURST_MAX = 8) → 8 wr_acks, then 1 rd_ack, repeating; never both acks in one cycle.
- Fill to 32768 words → full = 1, wr_ack = 0 with wr_req held. One read → full = 0, next write accepted at address 0 (wrap).
- 3 words stored, pulse sift_finish, then assert wr_req → no wr_ack. 3 reads complete → drain_done = 1 one cycle after the last rd_valid. rd_req in DONE is not acked.
- Issue rd_ack, then restart the next cycle → no rd_valid for that read; level = 0, wr_ptr = rd_ptr = 0, state RUN.
- With SIFTKEY_SCHED_STATS_EN, hold rd_req 10 cycles while empty → stall_rd_cnt = 10. Without the macro → stall_rd_cnt = 0.

Source files
------------

// File: rtl/siftkey_pkg.sv
// Shared types and defaults for the sifted-key BRAM scheduler.
package siftkey_pkg;

   localparam int unsigned SIFTKEY_ADDR_W       = 15;
   localparam int unsigned SIFTKEY_DATA_W       = 64;
   localparam int unsigned SIFTKEY_RD_LATENCY   = 2;
   localparam int unsigned SIFTKEY_WR_BURST_MAX = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/siftkey_bram_sched_if.sv
// Requester, BRAM-port and status signals of the sifted-key BRAM scheduler.
interface siftkey_bram_sched_if
   import siftkey_pkg::*;
#(
   parameter int unsigned ADDR_W = SIFTKEY_ADDR_W,
   parameter int unsigned DATA_W = SIFTKEY_DATA_W
);
   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              rd_req;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              sift_finish;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic [DATA_W-1:0] bram_dout;
   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W:0]   level;
   logic              full;
   logic              empty;
   logic              drain_done;
   logic [31:0]       stall_wr_cnt;
   logic [31:0]       stall_rd_cnt;

   modport slave (
      input  wr_req, wr_data, rd_req, sift_finish, bram_dout,
      output wr_ack, rd_ack, rd_data, rd_valid, bram_addr, bram_din, bram_en, bram_we,
      output level, full, empty, drain_done, stall_wr_cnt, stall_rd_cnt
   );

   modport master (
      output wr_req, wr_data, rd_req, sift_finish, bram_dout,
      input  wr_ack, rd_ack, rd_data, rd_valid, bram_addr, bram_din, bram_en, bram_we,
      input  level, full, empty, drain_done, stall_wr_cnt, stall_rd_cnt
   );
endinterface

// File: rtl/siftkey_bram_sched_grant_arb.sv
// Writer-priority two-way arbiter; after WR_BURST_MAX back-to-back writer grants
// with the reader waiting, the reader gets one slot.
module siftkey_grant_arb
   import siftkey_pkg::*;
#(
   parameter int unsigned WR_BURST_MAX = SIFTKEY_WR_BURST_MAX
) (
   input  logic clk_i,
   input  logic clear_i,
   input  logic wr_elig_i,
   input  logic rd_elig_i,
   output logic wr_gnt_o,
   output logic rd_gnt_o
);
   localparam int unsigned CntW = $clog2(WR_BURST_MAX + 1);

   logic [CntW-1:0] burst_q, burst_d;
   logic            rd_turn;

   assign rd_turn  = (burst_q == CntW'(WR_BURST_MAX));
   assign wr_gnt_o = wr_elig_i & ~(rd_elig_i & rd_turn);
   assign rd_gnt_o = rd_elig_i & ~wr_gnt_o;

   // Only writer grants made while the reader waits count toward starvation.
   always_comb begin
      burst_d = burst_q;
      if (!rd_elig_i || rd_gnt_o) begin
         burst_d = '0;
      end else if (wr_gnt_o) begin
         burst_d = burst_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end

endmodule

// File: rtl/siftkey_bram_sched.sv
// Circular-buffer scheduler for the single-port sifted-key BRAM with end-of-sift drain.
// Optional stall counters are built when SIFTKEY_SCHED_STATS_EN is defined.
module siftkey_bram_sched
   import siftkey_pkg::*;
#(
   parameter int unsigned ADDR_W       = SIFTKEY_ADDR_W,
   parameter int unsigned DATA_W       = SIFTKEY_DATA_W,
   parameter int unsigned RD_LATENCY   = SIFTKEY_RD_LATENCY,
   parameter int unsigned WR_BURST_MAX = SIFTKEY_WR_BURST_MAX
) (
   input logic                 clk_i,
   input logic                 reset_i,
   input logic                 restart_i,
   siftkey_bram_sched_if.slave bus
);
   localparam logic [ADDR_W:0]       Depth    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [RD_LATENCY-1:0] ValidBit = RD_LATENCY'(1) << (RD_LATENCY - 1);

   sched_state_t        state_q, state_d;
   logic                clear, full, empty, in_flight;
   logic                wr_allow, rd_allow, wr_elig, rd_elig, wr_gnt, rd_gnt;
   logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, addr_q, addr;
   logic [ADDR_W:0]     level_q, level_d;
   logic [RD_LATENCY-1:0] rd_pipe_q;
   logic [RD_LATENCY:0]   rd_chain;
   logic [DATA_W-1:0]   rd_data_q;

   assign clear   = reset_i | restart_i;
   assign full    = (level_q == Depth);
   assign empty   = (level_q == '0);
   assign wr_elig = bus.wr_req & ~full & wr_allow & ~clear;
   assign rd_elig = bus.rd_req & ~empty & rd_allow & ~clear;

   siftkey_grant_arb #(
      .WR_BURST_MAX(WR_BURST_MAX)
   ) u_arb (
      .clk_i    (clk_i),
      .clear_i  (clear),
      .wr_elig_i(wr_elig),
      .rd_elig_i(rd_elig),
      .wr_gnt_o (wr_gnt),
      .rd_gnt_o (rd_gnt)
   );

   always_comb begin
      addr    = addr_q;
      level_d = level_q;
      if (wr_gnt) begin
         addr    = wr_ptr_q;
         level_d = level_q + (ADDR_W + 1)'(1);
      end else if (rd_gnt) begin
         addr    = rd_ptr_q;
         level_d = level_q - (ADDR_W + 1)'(1);
      end
   end

   // rd_chain[k] is the read issued k cycles ago; the final stage is rd_valid and
   // rd_data is captured as a read enters it.
   assign rd_chain  = {rd_pipe_q, rd_gnt};
   assign in_flight = |(rd_pipe_q & ~ValidBit);

   always_ff @(posedge clk_i) begin
      if (clear) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         addr_q    <= '0;
         level_q   <= '0;
         rd_pipe_q <= '0;
         rd_data_q <= '0;
      end else begin
         if (wr_gnt) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (rd_gnt) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         addr_q    <= addr;
         level_q   <= level_d;
         rd_pipe_q <= rd_chain[RD_LATENCY-1:0];
         if (rd_chain[RD_LATENCY-1]) rd_data_q <= bus.bram_dout;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (bus.sift_finish) state_d = DRAIN;
         DRAIN:   if (empty && !in_flight) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      wr_allow = (state_q == RUN);
      rd_allow = (state_q != DONE);
   end

   assign bus.wr_ack     = wr_gnt;
   assign bus.rd_ack     = rd_gnt;
   assign bus.rd_valid   = rd_pipe_q[RD_LATENCY-1];
   assign bus.rd_data    = rd_data_q;
   assign bus.bram_addr  = addr;
   assign bus.bram_din   = bus.wr_data;
   assign bus.bram_en    = wr_gnt | rd_gnt;
   assign bus.bram_we    = wr_gnt;
   assign bus.level      = level_q;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.drain_done = (state_q == DONE);

`ifdef SIFTKEY_SCHED_STATS_EN
   logic [31:0] stall_wr_q, stall_rd_q;

   always_ff @(posedge clk_i) begin
      if (clear) begin
         stall_wr_q <= '0;
         stall_rd_q <= '0;
      end else begin
         if (bus.wr_req && !wr_gnt && state_q == RUN && stall_wr_q != '1) begin
            stall_wr_q <= stall_wr_q + 32'd1;
         end
         if (bus.rd_req && !rd_gnt && state_q != DONE && stall_rd_q != '1) begin
            stall_rd_q <= stall_rd_q + 32'd1;
         end
      end
   end

   assign bus.stall_wr_cnt = stall_wr_q;
   assign bus.stall_rd_cnt = stall_rd_q;
`else
   assign bus.stall_wr_cnt = '0;
   assign bus.stall_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_siftkey_bram_sched.sv
// Scoreboard bench for siftkey_bram_sched with a behavioural BRAM.
module tb_siftkey_bram_sched;
   import siftkey_pkg::*;

   localparam int unsigned RdLat = SIFTKEY_RD_LATENCY;
   localparam int unsigned Depth = 1 << SIFTKEY_ADDR_W;

   typedef struct {
      logic [63:0] data;
      int          due;
   } pend_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic restart = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [63:0] data_q[$];
   pend_t       pend_q[$];
   logic [63:0] mem [Depth];
   logic [63:0] dout_q = '0;

   siftkey_bram_sched_if bus ();

   siftkey_bram_sched dut (
      .clk_i    (clk),
      .reset_i  (reset),
      .restart_i(restart),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM with RdLat-1 output registers; the scheduler's rd_data register is the last stage.
   always @(posedge clk) begin
      if (bus.bram_en) begin
         if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
         else dout_q <= mem[bus.bram_addr];
      end
   end
   assign bus.bram_dout = dout_q;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: words queued on write accept, moved to pending on read issue, compared on rd_valid.
   always @(negedge clk) begin
      pend_t p;
      if (bus.rd_valid) begin
         if (pend_q.size() == 0) begin
            check("rd_valid_unexpected", 1, 0);
         end else begin
            p = pend_q.pop_front();
            check("rd_data", bus.rd_data, p.data);
            check("rd_latency", 64'(cyc), 64'(p.due));
         end
      end
      if (reset || restart) begin
         data_q.delete();
         pend_q.delete();
      end else begin
         if (bus.wr_ack) data_q.push_back(bus.wr_data);
         if (bus.rd_ack) begin
            if (data_q.size() == 0) begin
               check("rd_underflow", 1, 0);
            end else begin
               p.data = data_q.pop_front();
               p.due  = cyc + int'(RdLat);
               pend_q.push_back(p);
            end
         end
      end
   end

   task automatic do_write(input logic [63:0] d, output logic [SIFTKEY_ADDR_W-1:0] a);
      bit got = 0;
      a = '0;
      bus.wr_req  = 1'b1;
      bus.wr_data = d;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.wr_ack) begin
            got = 1;
            a   = bus.bram_addr;
            break;
         end
      end
      if (!got) check("wr_timeout", 0, 1);
      @(posedge clk);
      #1 bus.wr_req = 1'b0;
   endtask

   task automatic do_read(output logic [SIFTKEY_ADDR_W-1:0] a);
      bit got = 0;
      a = '0;
      bus.rd_req = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.rd_ack) begin
            got = 1;
            a   = bus.bram_addr;
            break;
         end
      end
      if (!got) check("rd_timeout", 0, 1);
      @(posedge clk);
      #1 bus.rd_req = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SIFTKEY_ADDR_W-1:0] a;
      logic [63:0] d;
      int last_valid, done_cyc, n_valid;

      bus.wr_req      = 1'b0;
      bus.wr_data     = '0;
      bus.rd_req      = 1'b0;
      bus.sift_finish = 1'b0;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_level", bus.level, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_drain_done", bus.drain_done, 0);
      @(posedge clk);
      #1;

      // Five words in, five out, FIFO order.
      for (int i = 0; i < 5; i++) begin
         do_write(64'h11 + 64'(i), a);
         check("t1_wr_addr", 64'(a), 64'(i));
         check("t1_level_up", bus.level, 64'(i + 1));
      end
      for (int i = 0; i < 5; i++) begin
         do_read(a);
         check("t1_level_down", bus.level, 64'(4 - i));
      end
      idle(RdLat + 2);
      check("t1_empty", bus.empty, 1);
      check("t1_sb_drained", 64'(pend_q.size()), 0);

      // Starvation guard: 8 writer grants, then one reader grant.
      pulse_restart();
      for (int i = 0; i < 4; i++) do_write(64'h200 + 64'(i), a);
      d = 64'h300;
      bus.wr_req  = 1'b1;
      bus.wr_data = d;
      bus.rd_req  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t2_wr_ack", bus.wr_ack, (i % 9) != 8);
         check("t2_rd_ack", bus.rd_ack, (i % 9) == 8);
         check("t2_one_ack", bus.wr_ack & bus.rd_ack, 0);
         if (bus.wr_ack) d = d + 1;
         @(posedge clk);
         #1 bus.wr_data = d;
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      idle(RdLat + 2);
      check("t2_level", bus.level, 20);
      check("t2_sb_drained", 64'(pend_q.size()), 0);

      // Fill to capacity, then free one slot and check the write pointer wrapped.
      pulse_restart();
      for (int i = 0; i < int'(Depth); i++) do_write(64'd1000 + 64'(i), a);
      check("t3_full", bus.full, 1);
      check("t3_level_full", bus.level, 64'(Depth));
      bus.wr_req  = 1'b1;
      bus.wr_data = 64'hDEAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_no_wr_when_full", bus.wr_ack, 0);
      end
      @(posedge clk);
      #1 bus.wr_req = 1'b0;
      do_read(a);
      check("t3_rd_addr", 64'(a), 0);
      check("t3_not_full", bus.full, 0);
      do_write(64'hDEAD, a);
      check("t3_wrap_addr", 64'(a), 0);
      check("t3_refull", bus.full, 1);
      idle(RdLat + 2);
      check("t3_sb_drained", 64'(pend_q.size()), 0);

      // Drain sequencing.
      pulse_restart();
      for (int i = 0; i < 3; i++) do_write(64'hA1 + 64'(i), a);
      bus.sift_finish = 1'b1;
      @(posedge clk);
      #1 bus.sift_finish = 1'b0;
      bus.wr_req  = 1'b1;
      bus.wr_data = 64'hBAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_no_wr_in_drain", bus.wr_ack, 0);
         check("t4_not_done_yet", bus.drain_done, 0);
      end
      @(posedge clk);
      #1 bus.wr_req = 1'b0;
      bus.rd_req = 1'b1;
      last_valid = -100;
      done_cyc   = -1;
      n_valid    = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.drain_done) begin
            done_cyc = cyc;
            break;
         end
         if (bus.rd_valid) begin
            last_valid = cyc;
            n_valid++;
         end
      end
      check("t4_valid_count", 64'(n_valid), 3);
      check("t4_done_timing", 64'(done_cyc), 64'(last_valid + 1));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t4_no_rd_in_done", bus.rd_ack, 0);
         check("t4_done_held", bus.drain_done, 1);
      end
      @(posedge clk);
      #1 bus.rd_req = 1'b0;

      // Restart with a read in flight: that read must never surface.
      pulse_restart();
      check("t5_run_after_restart", bus.drain_done, 0);
      do_write(64'hB1, a);
      do_write(64'hB2, a);
      bus.rd_req = 1'b1;
      @(negedge clk);
      check("t5_rd_ack", bus.rd_ack, 1);
      @(posedge clk);
      #1 bus.rd_req = 1'b0;
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      for (int i = 0; i < RdLat + 2; i++) begin
         @(negedge clk);
         check("t5_no_rd_valid", bus.rd_valid, 0);
      end
      check("t5_level", bus.level, 0);
      check("t5_empty", bus.empty, 1);
      @(posedge clk);
      #1;
      do_write(64'hC1, a);
      check("t5_wr_ptr_zero", 64'(a), 0);
      do_read(a);
      check("t5_rd_ptr_zero", 64'(a), 0);
      idle(RdLat + 2);
      check("t5_sb_drained", 64'(pend_q.size()), 0);

      // Stall counters: ten cycles of rd_req on an empty buffer.
      pulse_restart();
      bus.rd_req = 1'b1;
      idle(10);
      bus.rd_req = 1'b0;
      @(negedge clk);
`ifdef SIFTKEY_SCHED_STATS_EN
      check("t6_stall_rd", bus.stall_rd_cnt, 10);
`else
      check("t6_stall_rd", bus.stall_rd_cnt, 0);
`endif
      check("t6_stall_wr", bus.stall_wr_cnt, 0);
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
